// File: rtl/alarm_trigger.sv
// Alarm compare + ring/snooze/dismiss FSM driven by a 1 Hz enable; all outputs registered.
// Button edges are registered into pulses, so stop/snooze act 2 clk after the input edge.
module alarm_trigger #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic [1:0] CH1,
  input  logic [3:0] CH2,
  input  logic [2:0] CM1,
  input  logic [3:0] CM2,
  input  logic [1:0] AH1,
  input  logic [3:0] AH2,
  input  logic [2:0] AM1,
  input  logic [3:0] AM2,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzzer,
  output logic       led,
  output logic [1:0] state,
  output logic [1:0] snooze_left
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RINGING = 2'b01;
  localparam logic [1:0] ST_SNOOZE  = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = $clog2(MAX_SECS) + 1;

  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    SNZ_INIT    = 2'(MAX_SNOOZE);

  logic [1:0]    r_state;
  logic [1:0]    r_snooze_left;
  logic [CW-1:0] r_sec_cnt;
  logic          r_buzzer;
  logic          r_led;
  logic          r_stop_q;
  logic          r_snooze_q;
  logic          r_stop_p;
  logic          r_snooze_p;

  logic          w_match;
  logic [1:0]    w_nxt_state;
  logic [1:0]    w_nxt_snooze_left;
  logic          w_nxt_led;

  assign w_match = alarm_en & (CH1 == AH1) & (CH2 == AH2) & (CM1 == AM1) & (CM2 == AM2);

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_snooze_left = r_snooze_left;
    if (!alarm_en) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            w_nxt_state       = ST_RINGING;
            w_nxt_snooze_left = SNZ_INIT;
          end
        end
        ST_RINGING: begin
          if (r_stop_p) begin
            w_nxt_state = ST_DONE;
          end else if (r_snooze_p) begin
            if (r_snooze_left != 2'd0) begin
              w_nxt_state       = ST_SNOOZE;
              w_nxt_snooze_left = r_snooze_left - 2'd1;
            end else begin
              w_nxt_state = ST_DONE;
            end
          end else if (tick_1hz && (r_sec_cnt == RING_LAST)) begin
            w_nxt_state = ST_DONE;
          end
        end
        ST_SNOOZE: begin
          if (r_stop_p) begin
            w_nxt_state = ST_DONE;
          end else if (tick_1hz && (r_sec_cnt == SNOOZE_LAST)) begin
            w_nxt_state = ST_RINGING;
          end
        end
        default: begin
          // Wait for the matching minute to pass so the same event cannot re-trigger.
          if (!w_match) w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_nxt_led = 1'b0;
    if (w_nxt_state == ST_RINGING) begin
      if (r_state != ST_RINGING) w_nxt_led = 1'b1;
      else if (tick_1hz)         w_nxt_led = ~r_led;
      else                       w_nxt_led = r_led;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stop_q   <= 1'b0;
      r_snooze_q <= 1'b0;
      r_stop_p   <= 1'b0;
      r_snooze_p <= 1'b0;
    end else begin
      r_stop_q   <= stop;
      r_snooze_q <= snooze;
      r_stop_p   <= stop & ~r_stop_q;
      r_snooze_p <= snooze & ~r_snooze_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_snooze_left <= 2'd0;
      r_sec_cnt     <= '0;
      r_buzzer      <= 1'b0;
      r_led         <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_snooze_left <= w_nxt_snooze_left;
      r_buzzer      <= (w_nxt_state == ST_RINGING);
      r_led         <= w_nxt_led;
      // A tick landing on the entry edge is dropped by the clear.
      if (w_nxt_state != r_state) begin
        r_sec_cnt <= '0;
      end else if (tick_1hz && ((r_state == ST_RINGING) || (r_state == ST_SNOOZE))) begin
        r_sec_cnt <= r_sec_cnt + CW'(1);
      end
    end
  end

  assign state       = r_state;
  assign snooze_left = r_snooze_left;
  assign buzzer      = r_buzzer;
  assign led         = r_led;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: table of {inputs, expected outputs} plus hand-written reset sequences.
module tb_alarm_trigger;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       alarm_en;
  logic [1:0] CH1;
  logic [3:0] CH2;
  logic [2:0] CM1;
  logic [3:0] CM2;
  logic [1:0] AH1;
  logic [3:0] AH2;
  logic [2:0] AM1;
  logic [3:0] AM2;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic       led;
  logic [1:0] state;
  logic [1:0] snooze_left;

  alarm_trigger #(
    .RING_SECS   (5),
    .SNOOZE_SECS (3),
    .MAX_SNOOZE  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .alarm_en    (alarm_en),
    .CH1         (CH1),
    .CH2         (CH2),
    .CM1         (CM1),
    .CM2         (CM2),
    .AH1         (AH1),
    .AH2         (AH2),
    .AM1         (AM1),
    .AM2         (AM2),
    .stop        (stop),
    .snooze      (snooze),
    .buzzer      (buzzer),
    .led         (led),
    .state       (state),
    .snooze_left (snooze_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output packing: {buzzer, led, state[1:0], snooze_left[1:0]}
  typedef struct {
    logic        tick;
    logic        en;
    logic        stp;
    logic        snz;
    logic [15:0] cur;
    logic [15:0] alm;
    logic [5:0]  exp_out;
  } vec_t;

  localparam logic [15:0] A730 = 16'h0730;

  vec_t       tbl[$];
  logic [5:0] exp_q[$];
  string      name_q[$];
  int         n_cmp;
  int         n_err;

  function automatic vec_t mk(input logic t, input logic e, input logic sp, input logic sz,
                              input logic [15:0] c, input logic [15:0] a, input logic [5:0] x);
    vec_t v;
    v.tick = t; v.en = e; v.stp = sp; v.snz = sz; v.cur = c; v.alm = a; v.exp_out = x;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    tick_1hz = v.tick;
    alarm_en = v.en;
    stop     = v.stp;
    snooze   = v.snz;
    CH1 = v.cur[13:12]; CH2 = v.cur[11:8]; CM1 = v.cur[6:4]; CM2 = v.cur[3:0];
    AH1 = v.alm[13:12]; AH2 = v.alm[11:8]; AM1 = v.alm[6:4]; AM2 = v.alm[3:0];
  endtask

  task automatic check_pop();
    logic [5:0] x;
    logic [5:0] act;
    string      nm;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      x   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {buzzer, led, state, snooze_left};
      n_cmp++;
      if (act !== x) begin
        n_err++;
        $display("FAIL %s: got buz=%b led=%b st=%b sl=%b, want buz=%b led=%b st=%b sl=%b",
                 nm, act[5], act[4], act[3:2], act[1:0], x[5], x[4], x[3:2], x[1:0]);
      end
    end
  endtask

  // Called at posedge+1: drive, queue expectation, sample one cycle later.
  task automatic step(input vec_t v, input string nm);
    apply(v);
    exp_q.push_back(v.exp_out);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic check_now(input logic [5:0] x, input string nm);
    exp_q.push_back(x);
    name_q.push_back(nm);
    check_pop();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    apply(mk(0, 0, 0, 0, 16'h0000, A730, 6'b0));

    // Ring then auto-dismiss on 5th tick; DONE holds through the matching minute.
    tbl.push_back(mk(0, 1, 0, 0, 16'h0729, A730, 6'b0_0_00_00));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_0_01_10));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_0_01_10));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_0_01_10));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b0_0_11_10));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b0_0_11_10));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0731, A730, 6'b0_0_00_10));
    // Three snoozes: two re-rings, the third press dismisses.
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b0_0_10_01));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b0_0_10_01));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b0_0_10_01));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_01));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b1_1_01_01));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b0_0_10_00));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b0_0_10_00));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b0_0_10_00));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_00));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b1_1_01_00));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b0_0_11_00));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0731, A730, 6'b0_0_00_00));
    // Stop and snooze together: stop wins, snooze_left untouched.
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(0, 1, 1, 1, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(0, 1, 1, 1, 16'h0730, A730, 6'b0_0_11_10));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0731, A730, 6'b0_0_00_10));
    // alarm_en drop in SNOOZE and in RINGING (with a tick), re-enable re-rings.
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0730, A730, 6'b0_0_10_01));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0730, A730, 6'b0_0_00_01));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0730, A730, 6'b0_0_00_10));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0730, A730, 6'b0_0_00_10));
    // Alarm digits change mid-ring: event continues until stopped.
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, A730,     6'b1_1_01_10));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0730, 16'h0845, 6'b1_0_01_10));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0730, 16'h0845, 6'b1_0_01_10));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0730, 16'h0845, 6'b0_0_11_10));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0730, 16'h0845, 6'b0_0_00_10));

    #1;
    check_now(6'b0, "reset_state");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Async reset mid-ring, stop held across release with match present.
    step(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10), "rst_setup_ring");
    step(mk(1, 1, 0, 0, 16'h0730, A730, 6'b1_0_01_10), "rst_setup_tick");
    #2;
    rst  = 1'b0;
    stop = 1'b1;
    #1;
    check_now(6'b0, "async_reset_no_edge");
    @(posedge clk); #1;
    check_now(6'b0, "reset_held");
    rst = 1'b1;
    step(mk(0, 1, 1, 0, 16'h0730, A730, 6'b1_1_01_10), "stop_held_match_ring");
    step(mk(0, 1, 1, 0, 16'h0730, A730, 6'b0_0_11_10), "stop_held_match_done");

    // Same, but without match: the release-time edge is spent in IDLE.
    #2;
    rst = 1'b0;
    apply(mk(0, 1, 1, 0, 16'h0731, A730, 6'b0));
    #1;
    check_now(6'b0, "async_reset_from_done");
    @(posedge clk); #1;
    rst = 1'b1;
    step(mk(0, 1, 1, 0, 16'h0731, A730, 6'b0_0_00_00), "stop_held_nomatch_idle");
    step(mk(0, 1, 1, 0, 16'h0731, A730, 6'b0_0_00_00), "stop_held_nomatch_idle2");
    step(mk(0, 1, 1, 0, 16'h0730, A730, 6'b1_1_01_10), "stop_held_then_match");
    step(mk(0, 1, 1, 0, 16'h0730, A730, 6'b1_1_01_10), "stop_level_no_pulse");
    step(mk(0, 1, 0, 0, 16'h0730, A730, 6'b1_1_01_10), "stop_released");
    step(mk(0, 1, 1, 0, 16'h0730, A730, 6'b1_1_01_10), "stop_new_edge");
    step(mk(0, 1, 1, 0, 16'h0730, A730, 6'b0_0_11_10), "stop_new_edge_done");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

Downstream consumer of the alarm-setting stage: compares the running clock time (HH:MM as BCD-style digits) against the stored alarm digits and runs the ringing/snooze/dismiss state machine. It drives the buzzer and the alarm LED for the top-level display and annunciator. Timing is derived from a one-cycle 1 Hz enable pulse supplied by the timebase; there is no second clock.

## Interface
- `RING_SECS`, default 60: seconds the buzzer rings before auto-dismiss.
- `SNOOZE_SECS`, default 300: seconds spent silent in snooze before re-ringing.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event.

Ports:
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `tick_1hz` input 1: one-`clk`-wide pulse, once per second.
- `alarm_en` input 1: alarm arm switch (level).
- `CH1` input 2 / `CH2` input 4 / `CM1` input 3 / `CM2` input 4: current time digits (hour tens, hour units, minute tens, minute units).
- `AH1` input 2 / `AH2` input 4 / `AM1` input 3 / `AM2` input 4: alarm time digits, same encoding.
- `stop` input 1: debounced dismiss button (level).
- `snooze` input 1: debounced snooze button (level).
- `buzzer` output 1: buzzer drive.
- `led` output 1: alarm LED; blinks while ringing.
- `state` output 2: FSM state, IDLE=00, RINGING=01, SNOOZE=10, DONE=11.
- `snooze_left` output 2: remaining snoozes for the current event.

## Operation
- `match` = `alarm_en` AND all four digit pairs equal (combinational).
- `stop` and `snooze` are rising-edge detected internally (previous-value registers). `stop_p` / `snooze_p` are one-cycle pulses.
- `sec_cnt` counts `tick_1hz` pulses in RINGING and SNOOZE.
  - Width: `$clog2(max(RING_SECS, SNOOZE_SECS))+1`.
  - Cleared on every state entry.
- State transitions:
  - IDLE:
    - `match` -> RINGING; `sec_cnt`=0; `snooze_left`=MAX_SNOOZE.
  - RINGING:
    - `stop_p` -> DONE.
    - Else `snooze_p` with `snooze_left`>0 -> SNOOZE, `snooze_left` decremented.
    - Else `snooze_p` with `snooze_left`=0 -> DONE.
    - Else `tick_1hz` with `sec_cnt`==RING_SECS-1 -> DONE.
  - SNOOZE:
    - `stop_p` -> DONE.
    - Else `tick_1hz` with `sec_cnt`==SNOOZE_SECS-1 -> RINGING.
  - DONE:
    - `match`==0 -> IDLE. This prevents re-triggering within the same minute.
- `alarm_en`==0 forces IDLE from any state on the next edge, with priority over everything else; `buzzer`/`led` clear.
- Priority within a cycle: `alarm_en` low > `stop_p` > `snooze_p` > timeout.
- `buzzer` = 1 exactly in RINGING.
- `led`:
  - Toggles on each `tick_1hz` while in RINGING.
  - Set to 1 on entry to RINGING.
  - 0 in every other state.
- `snooze_left` holds its value in SNOOZE and DONE. It is reloaded only on IDLE->RINGING.
- Alarm digit changes while RINGING/SNOOZE do not abort the event; only stop, timeout or `alarm_en` low end it.

## Timing
- Reset values, asynchronous on `rst` low:
  - `state`=IDLE, `buzzer`=0, `led`=0, `snooze_left`=0, `sec_cnt`=0.
  - Edge-detect registers=0.
- All outputs are registered.
- `buzzer` rises one `clk` after the first cycle `match` is high.
- `stop` rising edge: the sampled cycle yields `stop_p`; `buzzer` falls at the following edge, so 2 `clk` from the input edge.
- Auto-dismiss occurs on the RING_SECS-th tick after RINGING entry. Snooze re-ring occurs on the SNOOZE_SECS-th tick after SNOOZE entry.
- A `tick_1hz` coinciding with the entry cycle is not counted.
- Reset mid-ring clears to IDLE immediately. If `match` is still true after reset release, the alarm re-rings (intended).

## Test plan
- Parameters RING_SECS=5, SNOOZE_SECS=3, MAX_SNOOZE=2.
- Clock 07:29->07:30 with alarm 07:30, `alarm_en`=1 -> `buzzer`=1 one `clk` after the digits match; `state`=01; `snooze_left`=2; `led` toggles on each tick.
- Ring with no input -> `buzzer`=0, `state`=11 on the 5th tick. While the time stays 07:30, `state` stays 11. At 07:31, `state`=00.
- Snooze three times across re-rings:
  - 1st snooze -> SNOOZE, `snooze_left`=1; RINGING after 3 ticks.
  - 2nd snooze -> `snooze_left`=0.
  - 3rd snooze -> DONE.
- `stop` and `snooze` rising in the same cycle while RINGING -> DONE (stop wins); `snooze_left` unchanged.
- `alarm_en` dropped during SNOOZE -> IDLE next edge, `buzzer`=`led`=0. Re-enable while the time is still 07:30 -> re-ring.
- `rst` asserted mid-RINGING asynchronously -> all outputs 0 without a `clk` edge. Hold `stop` high across reset release -> DONE only if `match` (first-cycle edge seen as rising).
